wb_cmd_master: RTL

Wishbone classic single-transfer initiator for the user project area. Converts a valid/ready command stream (address, data, byte select, direction) into one Wishbone B4 classic cycle, then returns read data and status on a valid/ready response stream. It is the master end of the 32-bit Wishbone slave interface used by user-area peripherals, letting on-chip logic (LA-driven sequencers, test engines) drive those peripherals without the management SoC.

---
 rtl/wb_cmd_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer initiator: valid/ready command in, one bus cycle, valid/ready response out.
// Optional ack timeout is built only when WB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// BUS   | cyc/stb asserted, waiting for ack (or timeout)
// RESP  | rsp_valid high, holding rsp_dat/rsp_err until rsp_ready
module wb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state, state_nxt;
  logic   ready_en;
  logic   cmd_fire;
  logic   timeout_hit;

  // Holds cmd_ready low while reset is asserted, even though state is already IDLE.
  always_ff @(posedge clk) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign cmd_ready = (state == IDLE) && ready_en;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wbm_cyc_o = (state == BUS);
  assign wbm_stb_o = (state == BUS);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      to_cnt <= '0;
    else if (cmd_fire)
      to_cnt <= '0;
    else if (state == BUS && !wbm_ack_i && to_cnt != '1)
      to_cnt <= to_cnt + 1'b1;
  end

  // to_cnt holds n-1 during BUS cycle n; an ack on the final cycle still wins.
  assign timeout_hit = (state == BUS) && !wbm_ack_i &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = BUS;
      BUS:     if (wbm_ack_i || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else if (cmd_fire) begin
      wbm_we_o  <= cmd_we;
      wbm_sel_o <= cmd_sel;
      wbm_adr_o <= cmd_adr;
      wbm_dat_o <= cmd_dat;
    end
  end

  // Writes also return whatever the slave drives on dat_i at ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else if (state == BUS) begin
      if (wbm_ack_i) begin
        rsp_dat <= wbm_dat_i;
        rsp_err <= 1'b0;
      end else if (timeout_hit) begin
        rsp_dat <= TIMEOUT_DATA;
        rsp_err <= 1'b1;
      end
    end
  end

endmodule
